sobel_stage: RTL and testbench
==============================

# sobel_stage

Streaming 3x3 Sobel edge-magnitude stage that sits directly downstream of the 3x3 sliding-window buffer. It consumes the registered window each cycle, tracks row and column position from its own valid/frame-start qualifiers, and computes |Gx|+|Gy| saturated to 8 bits. Results go through a 3-stage pipeline and are emitted as a one-to-one output pixel stream for the display/writeback stage.

## Interface
- ROW_WIDTH, 640, pixels per row; must equal the sliding window's ROW_WIDTH.
- ROW_COUNT, 480, rows per frame.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; all state is cleared while low.
- in_valid  in  1  high in every cycle the upstream window is fed a real pixel. Contiguous within a row.
- frame_start  in  1  qualified by in_valid; marks pixel (0,0) of a frame.
- window  in  8 x [3][3]  window from the sliding buffer; [0][0] is oldest/top-left, [2][2] is newest.
- pixel_out  out  8  edge magnitude.
- out_valid  out  1  pixel_out is valid.
- frame_done  out  1  one-cycle pulse coincident with the last out_valid of a frame.

## Operation
- Alignment:
  - The window reflects the pixel fed in cycle t during cycle t+1.
  - in_valid and frame_start are registered once internally (stage 0) so they align with the window.
- Position counters (col 0..ROW_WIDTH-1, row 0..ROW_COUNT-1) advance on each aligned valid.
  - col wraps to 0 and row increments.
  - At (ROW_COUNT-1, ROW_WIDTH-1), both wrap to 0 and frame_done is tagged.
  - An aligned frame_start forces the current pixel to (0,0), overriding the counters, even mid-frame.
- Kernel, with p[r][c] = window[r][c]:
  - Gx = (p02+2p12+p22) − (p00+2p10+p20)
  - Gy = (p20+2p21+p22) − (p00+2p01+p02)
- Widths:
  - Partial sums are 10-bit unsigned (max 1020).
  - Gx and Gy are 11-bit signed.
  - |Gx|+|Gy| is 11-bit unsigned (max 2040).
  - The result saturates to 255 when above 255.
- Border: if row<2 or col<2, the window is incomplete or straddles a row wrap. Output 0, but out_valid is still asserted so output pixel count equals input count.
- Output pixel for input position (r,c) is the gradient centred at (r−1,c−1).
- in_valid low: stages carry a bubble (valid=0); data registers may hold. No stall/backpressure exists.

## Timing
- Pipeline:
  - stage0: align valid/flags.
  - stage1: register partial sums and the border flag.
  - stage2: register |Gx| and |Gy|.
  - stage3: sum, saturate and register the outputs.
- Latency: in_valid in cycle t → out_valid in cycle t+4. Throughput is 1 pixel/cycle.
- Reset values: pixel_out=0, out_valid=0, frame_done=0, all counters and stage valids 0.
- Reset asserted mid-frame:
  - All in-flight pixels are dropped immediately (asynchronous).
  - After release, the first pixel is treated as (0,0) whether or not frame_start is high.
- frame_start arriving with counters mid-frame: pixels already in flight finish with their old coordinates; no frame_done is emitted for the truncated frame.
- frame_done and out_valid are both high in the same cycle; frame_done is never high while out_valid is low.

## Configuration
- SOBEL_THRESHOLD_EN defined:
  - Adds input port threshold (in, 8).
  - pixel_out = 255 if the saturated magnitude ≥ threshold, else 0. Border pixels are still 0.
  - threshold is sampled at stage3.
- Not defined: no threshold port; pixel_out is the saturated magnitude. Latency is identical in both builds.

## Structure
- Shared package img_pkg:
  - pixel_t (8-bit).
  - KERNEL_SIZE=3.
  - PIX_MAX=255.
  - grad_t (11-bit signed).
  - mag_t (11-bit unsigned).
- Sub-module sobel_kernel_pipe: stages 1–3 of the arithmetic pipeline, carrying valid/border/frame_done sideband. The top level owns stage0 alignment and the position counters.

## Test plan
- Uniform frame of value 100 (ROW_WIDTH=8, ROW_COUNT=4) → 32 out_valid pulses, all pixel_out=0, single frame_done on the 32nd, first out_valid 4 cycles after first in_valid.
- Every row = columns 0,0,0,10,10,10,10,10 → interior outputs at the step positions equal 40, border rows/cols 0, flat regions 0.
- Step from 0 to 255 → interior step pixels saturate to 255, never wrap.
- in_valid toggled 1/0 each cycle → out_valid follows the same pattern delayed 4 cycles; values are identical to the continuous run.
- reset pulsed low mid-row 2 → outputs go to 0 immediately. The next frame started after release produces the correct results and frame_done.
- With SOBEL_THRESHOLD_EN and threshold=40 on the 0→10 step → step pixels 255, all others 0; threshold=41 → all 0.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image-pipeline types and helpers for the Sobel stage.
package img_pkg;

  localparam int unsigned PIX_W       = 8;
  localparam int unsigned KERNEL_SIZE = 3;
  localparam int unsigned PIX_MAX     = 255;
  localparam int unsigned PSUM_W      = 10;
  localparam int unsigned GRAD_W      = 11;

  typedef logic [PIX_W-1:0]         pixel_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [GRAD_W-1:0]        mag_t;
  typedef logic [PSUM_W-1:0]        psum_t;

  // window[r][c]: [0][0] oldest/top-left, [2][2] newest/bottom-right
  typedef pixel_t [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] window_t;

  // Sideband carried alongside each pixel through the arithmetic pipeline
  typedef struct packed {
    logic valid;
    logic border;
    logic frame_done;
  } side_t;

  // Weighted 1-2-1 partial sums feeding Gx and Gy
  typedef struct packed {
    psum_t gx_pos;
    psum_t gx_neg;
    psum_t gy_pos;
    psum_t gy_neg;
  } psum_bus_t;

  // a + 2b + c, max 1020, fits 10 bits unsigned
  function automatic psum_t col_sum(input pixel_t a, input pixel_t b, input pixel_t c);
    return psum_t'(a) + psum_t'({b, 1'b0}) + psum_t'(c);
  endfunction

  // Absolute value of a signed gradient (|g| <= 1020, no overflow)
  function automatic mag_t abs_grad(input grad_t g);
    return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
  endfunction

endpackage

// File: rtl/sobel_stage_kernel_pipe.sv
// sobel_kernel_pipe: stages 1-3 of the Sobel arithmetic pipeline.
// Optional SOBEL_THRESHOLD_EN turns the magnitude into a binary edge map.
import img_pkg::*;

module sobel_kernel_pipe (
  input  logic    clk,
  input  logic    reset,
  input  logic    in_valid,
  input  logic    border,
  input  logic    frame_tag,
  input  window_t window,
`ifdef SOBEL_THRESHOLD_EN
  input  pixel_t  threshold,
`endif
  output pixel_t  pixel_out,
  output logic    out_valid,
  output logic    frame_done
);

  side_t     s1_side;
  side_t     s2_side;
  psum_bus_t s1_sum;
  mag_t      s2_mag_x;
  mag_t      s2_mag_y;

  grad_t     gx_c;
  grad_t     gy_c;
  mag_t      mag_sum_c;
  pixel_t    sat_c;
  pixel_t    result_c;

  // Stage 1: register partial sums and sideband
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_side <= '0;
      s1_sum  <= '0;
    end else begin
      s1_side <= '{valid: in_valid, border: in_valid & border, frame_done: in_valid & frame_tag};
      if (in_valid) begin
        s1_sum.gx_pos <= col_sum(window[0][2], window[1][2], window[2][2]);
        s1_sum.gx_neg <= col_sum(window[0][0], window[1][0], window[2][0]);
        s1_sum.gy_pos <= col_sum(window[2][0], window[2][1], window[2][2]);
        s1_sum.gy_neg <= col_sum(window[0][0], window[0][1], window[0][2]);
      end
    end
  end

  // Signed gradients from the partial sums (zero-extended to 11 bits)
  always_comb begin
    gx_c = grad_t'(s1_sum.gx_pos) - grad_t'(s1_sum.gx_neg);
    gy_c = grad_t'(s1_sum.gy_pos) - grad_t'(s1_sum.gy_neg);
  end

  // Stage 2: register |Gx| and |Gy|
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_side  <= '0;
      s2_mag_x <= '0;
      s2_mag_y <= '0;
    end else begin
      s2_side <= s1_side;
      if (s1_side.valid) begin
        s2_mag_x <= abs_grad(gx_c);
        s2_mag_y <= abs_grad(gy_c);
      end
    end
  end

  // Magnitude sum, saturation, border zeroing and optional threshold
  always_comb begin
    mag_sum_c = s2_mag_x + s2_mag_y;
    sat_c     = (mag_sum_c > mag_t'(PIX_MAX)) ? pixel_t'(PIX_MAX) : pixel_t'(mag_sum_c);
`ifdef SOBEL_THRESHOLD_EN
    result_c  = (sat_c >= threshold) ? pixel_t'(PIX_MAX) : '0;
`else
    result_c  = sat_c;
`endif
    if (s2_side.border) begin
      result_c = '0;
    end
  end

  // Stage 3: registered outputs; pixel_out holds across bubbles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_out  <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= s2_side.valid;
      frame_done <= s2_side.valid & s2_side.frame_done;
      if (s2_side.valid) begin
        pixel_out <= result_c;
      end
    end
  end

endmodule

// File: rtl/sobel_stage.sv
// sobel_stage: streaming 3x3 Sobel |Gx|+|Gy| stage, 4-cycle latency.
// Owns input alignment (stage 0) and row/column tracking.
// Optional macro SOBEL_THRESHOLD_EN adds a threshold input port.
import img_pkg::*;

module sobel_stage #(
  parameter int unsigned ROW_WIDTH = 640,
  parameter int unsigned ROW_COUNT = 480
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    in_valid,
  input  logic    frame_start,
  input  window_t window,
`ifdef SOBEL_THRESHOLD_EN
  input  pixel_t  threshold,
`endif
  output pixel_t  pixel_out,
  output logic    out_valid,
  output logic    frame_done
);

  localparam int unsigned COL_W = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
  localparam int unsigned ROW_W = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;

  logic             v0;
  logic             fs0;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_cur_c;
  logic [ROW_W-1:0] row_cur_c;
  logic             last_col_c;
  logic             last_c;
  logic             border_c;

  // Stage 0: align valid/frame_start with the registered window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0  <= 1'b0;
      fs0 <= 1'b0;
    end else begin
      v0  <= in_valid;
      fs0 <= in_valid & frame_start;
    end
  end

  // Position of the aligned pixel; frame_start forces (0,0)
  always_comb begin
    col_cur_c  = fs0 ? '0 : col_q;
    row_cur_c  = fs0 ? '0 : row_q;
    last_col_c = (col_cur_c == COL_W'(ROW_WIDTH - 1));
    last_c     = last_col_c && (row_cur_c == ROW_W'(ROW_COUNT - 1));
    border_c   = (row_cur_c < ROW_W'(2)) || (col_cur_c < COL_W'(2));
  end

  // Counters hold the position expected for the next aligned pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (v0) begin
      if (last_col_c) begin
        col_q <= '0;
        row_q <= last_c ? '0 : row_cur_c + ROW_W'(1);
      end else begin
        col_q <= col_cur_c + COL_W'(1);
        row_q <= row_cur_c;
      end
    end
  end

  sobel_kernel_pipe u_pipe (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (v0),
    .border     (border_c),
    .frame_tag  (last_c),
    .window     (window),
`ifdef SOBEL_THRESHOLD_EN
    .threshold  (threshold),
`endif
    .pixel_out  (pixel_out),
    .out_valid  (out_valid),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_sobel_stage.sv
// Scoreboard bench for sobel_stage on an 8x4 frame.
import img_pkg::*;

module tb_sobel_stage;

  localparam int unsigned RW = 8;
  localparam int unsigned RC = 4;

  logic    clk = 1'b0;
  logic    reset;
  logic    in_valid;
  logic    frame_start;
  window_t window;
  pixel_t  pixel_out;
  logic    out_valid;
  logic    frame_done;
`ifdef SOBEL_THRESHOLD_EN
  pixel_t  threshold;
`endif

  sobel_stage #(.ROW_WIDTH(RW), .ROW_COUNT(RC)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .frame_start (frame_start),
    .window      (window),
`ifdef SOBEL_THRESHOLD_EN
    .threshold   (threshold),
`endif
    .pixel_out   (pixel_out),
    .out_valid   (out_valid),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pix;
    int fd;
    int cyc;
  } exp_t;

  exp_t    sb[$];
  exp_t    e;
  int      img[RC][RW];
  int      tests    = 0;
  int      fails    = 0;
  int      cyc      = 0;
  int      fd_seen  = 0;
  int      out_seen = 0;
  int      thr      = 0;
  window_t last_win;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void fill(input int kind, input int hi);
    for (int r = 0; r < RC; r++)
      for (int c = 0; c < RW; c++)
        img[r][c] = (kind == 0) ? hi : ((c >= 3) ? hi : 0);
  endfunction

  // Reference magnitude for the pixel fed at (r,c), centred at (r-1,c-1)
  function automatic int expect_pix(input int r, input int c);
    int p[3][3];
    int gx, gy, m;
    if (r < 2 || c < 2) return 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = img[r-2+i][c-2+j];
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m > 255) m = 255;
`ifdef SOBEL_THRESHOLD_EN
    m = (m >= thr) ? 255 : 0;
`endif
    return m;
  endfunction

  function automatic window_t win_of(input int r, input int c);
    window_t w;
    int rr, cc;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        rr = r - 2 + i;
        cc = c - 2 + j;
        if (rr >= 0 && cc >= 0) w[i][j] = pixel_t'(img[rr][cc]);
        else                    w[i][j] = '0;
      end
    return w;
  endfunction

  // Feed one pixel; the window for it is presented one cycle later
  task automatic feed(input int r, input int c, input bit fs, input bit gap);
    @(negedge clk);
    window      = last_win;
    in_valid    = 1'b1;
    frame_start = fs;
    sb.push_back('{pix: expect_pix(r, c), fd: int'(r == RC-1 && c == RW-1), cyc: cyc + 4});
    last_win    = win_of(r, c);
    if (gap) begin
      @(negedge clk);
      window      = last_win;
      in_valid    = 1'b0;
      frame_start = 1'b0;
    end
  endtask

  task automatic feed_frame(input bit fs_first, input bit gap);
    for (int r = 0; r < RC; r++)
      for (int c = 0; c < RW; c++)
        feed(r, c, fs_first && r == 0 && c == 0, gap);
  endtask

  task automatic drain(input string tag, input int n_out, input int n_fd);
    @(negedge clk);
    window      = last_win;
    in_valid    = 1'b0;
    frame_start = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check({tag, "_drain"}, sb.size(), 0);
    check({tag, "_nout"}, out_seen, n_out);
    check({tag, "_nfd"}, fd_seen, n_fd);
    out_seen = 0;
    fd_seen  = 0;
  endtask

  // Output monitor: pop and compare every out_valid
  always @(posedge clk) begin
    cyc++;
    #1;
    if (out_valid) begin
      out_seen++;
      if (frame_done) fd_seen++;
      if (sb.size() == 0) check("spurious_out", 1, 0);
      else begin
        e = sb.pop_front();
        check("pix", int'(pixel_out), e.pix);
        check("fd", int'(frame_done), e.fd);
        check("lat", cyc, e.cyc);
      end
    end else begin
      check("fd_idle", int'(frame_done), 0);
    end
  end

  initial begin
    reset       = 1'b0;
    in_valid    = 1'b0;
    frame_start = 1'b0;
    window      = '0;
    last_win    = '0;
`ifdef SOBEL_THRESHOLD_EN
    threshold   = '0;
`endif
    #1;
    check("rst_pix", int'(pixel_out), 0);
    check("rst_ov", int'(out_valid), 0);
    check("rst_fd", int'(frame_done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    fill(0, 100);
    feed_frame(1'b1, 1'b0);
    drain("uniform", 32, 1);

    fill(1, 10);
    feed_frame(1'b1, 1'b0);
    drain("step10", 32, 1);

    fill(1, 255);
    feed_frame(1'b1, 1'b0);
    drain("step255", 32, 1);

    fill(1, 10);
    feed_frame(1'b1, 1'b1);
    drain("toggle", 32, 1);

    // Truncated frame restarted by frame_start: no frame_done for it
    fill(1, 255);
    for (int i = 0; i < 10; i++) feed(i / RW, i % RW, i == 0, 1'b0);
    feed_frame(1'b1, 1'b0);
    drain("restart", 42, 1);

    // Reset mid-row 2 with a nonzero pixel on the output
    for (int i = 0; i < 2*RW + 7; i++) feed(i / RW, i % RW, i == 0, 1'b0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    #1;
    check("midrst_pix", int'(pixel_out), 0);
    check("midrst_ov", int'(out_valid), 0);
    check("midrst_fd", int'(frame_done), 0);
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    last_win = '0;
    out_seen = 0;
    fd_seen  = 0;
    feed_frame(1'b0, 1'b0);
    drain("postrst", 32, 1);

`ifdef SOBEL_THRESHOLD_EN
    fill(1, 10);
    thr       = 40;
    threshold = 8'd40;
    feed_frame(1'b1, 1'b0);
    drain("thr40", 32, 1);
    thr       = 41;
    threshold = 8'd41;
    feed_frame(1'b1, 1'b0);
    drain("thr41", 32, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
